// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit (radix-2 shift-add multiply,
// restoring divide on magnitudes), one iteration per clock, WIDTH cycles per op.
// Optional feature: define MUL_DIV_UNIT_MACC_EN to enable MADD/MADDU/MSUB/MSUBU
// accumulation into {HI,LO}; otherwise op 1xx behaves as a plain multiply.
// Ports:
//   clk, resetn            clock, async active-low reset
//   start, op, a, b        launch request, opcode, rs/rt operands
//   flush                  abort in-flight operation
//   hi_we, lo_we, wdata    direct HI/LO write (MTHI/MTLO)
//   busy, done             CALC indicator, one-cycle completion pulse
//   hi, lo                 architectural HI/LO registers
//   div_by_zero            divide-by-zero flag, valid with done
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic             is_div_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mcand_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dbz_q;
    logic             accept, finish, dz;
`ifdef MUL_DIV_UNIT_MACC_EN
    logic             macc_q, msub_q;
`endif

    // Operand preparation at accept: magnitudes plus result sign flags
    logic             is_div_in, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign is_div_in = (op[2:1] == 2'b01);
    assign a_neg     = ~op[0] & a[WIDTH-1];
    assign b_neg     = ~op[0] & b[WIDTH-1];
    assign a_mag     = a_neg ? WIDTH'(~a + 1'b1) : a;
    assign b_mag     = b_neg ? WIDTH'(~b + 1'b1) : b;

    // One iteration step for the current operation
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_n, lo_n;
    always_comb begin
        mul_sum   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q}) : {1'b0, acc_hi_q};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        // top bit of the difference is the borrow
        div_ge    = ~div_diff[WIDTH];
        if (is_div_q) begin
            hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_n = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Final result from the last iteration, with sign correction
    logic [PW-1:0]    prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, res_hi, res_lo;
    always_comb begin
        prod   = {hi_n, lo_n};
        prod_s = neg_quo_q ? PW'(~prod + 1'b1) : prod;
        quo_s  = neg_quo_q ? WIDTH'(~lo_n + 1'b1) : lo_n;
        rem_s  = neg_rem_q ? WIDTH'(~hi_n + 1'b1) : hi_n;
        {res_hi, res_lo} = prod_s;
        if (is_div_q) begin
            res_hi = rem_s;
            res_lo = quo_s;
        end
`ifdef MUL_DIV_UNIT_MACC_EN
        else if (macc_q) begin
            {res_hi, res_lo} = msub_q ? PW'({hi_q, lo_q} - prod_s) : PW'({hi_q, lo_q} + prod_s);
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        dz      = 1'b0;
        case (state_q)
            IDLE: accept = start & ~flush;
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (count_q == CW'(WIDTH - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start & ~flush;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            // divide by zero skips CALC and leaves HI/LO alone
            dz      = is_div_in & (b == '0);
            state_d = dz ? DONE : CALC;
        end
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MUL_DIV_UNIT_MACC_EN
            macc_q    <= 1'b0;
            msub_q    <= 1'b0;
`endif
        end else begin
            busy_q <= (state_d == CALC);
            done_q <= (state_d == DONE);
            dbz_q  <= dz;
            if (accept) begin
                count_q   <= '0;
                is_div_q  <= is_div_in;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                acc_hi_q  <= '0;
                acc_lo_q  <= a_mag;
                mcand_q   <= b_mag;
`ifdef MUL_DIV_UNIT_MACC_EN
                macc_q    <= op[2];
                msub_q    <= op[1];
`endif
            end else if (state_q == CALC) begin
                count_q  <= count_q + 1'b1;
                acc_hi_q <= hi_n;
                acc_lo_q <= lo_n;
            end
            // result write wins over a same-edge MTHI/MTLO
            if (finish) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
